// File: rtl/poly_chord_player.sv
// Polyphonic chord player: voice allocation, beat-driven note durations
// and a saturating mixer of the per-voice sample streams.
module poly_chord_player #(
   parameter int NUM_VOICES   = 4,
   parameter int NOTE_WIDTH   = 6,
   parameter int DUR_WIDTH    = 6,
   parameter int SAMPLE_WIDTH = 16,
   parameter bit STEAL_EN     = 1'b0
) (
   input  logic                               clk,
   input  logic                               reset,
   input  logic                               play_enable,
   input  logic [NOTE_WIDTH-1:0]              note_to_load,
   input  logic [DUR_WIDTH-1:0]               duration,
   input  logic                               load_new_note,
   input  logic                               advance,
   input  logic                               beat,
   input  logic [NUM_VOICES*SAMPLE_WIDTH-1:0] voice_sample,
   input  logic [NUM_VOICES-1:0]              voice_ready,
   output logic [NUM_VOICES*NOTE_WIDTH-1:0]   voice_note,
   output logic [NUM_VOICES-1:0]              voice_load,
   output logic [NUM_VOICES-1:0]              voice_done,
   output logic                               advance_done,
   output logic                               all_done,
   output logic [SAMPLE_WIDTH-1:0]            mix_sample,
   output logic                               sample_ready,
   output logic [7:0]                         drop_count
);

   localparam int NV = NUM_VOICES;
   localparam int SW = SAMPLE_WIDTH;
   localparam int IW = (NV > 1) ? $clog2(NV) : 1;
   localparam int AW = SW + 4;

   localparam logic signed [AW-1:0] MAXV = {{5{1'b0}}, {(SW-1){1'b1}}};
   localparam logic signed [AW-1:0] MINV = {{5{1'b1}}, {(SW-1){1'b0}}};

   logic [NV-1:0][DUR_WIDTH-1:0]  cnt_q, cnt_d;
   logic [DUR_WIDTH-1:0]          timer_q, timer_d;
   logic [NV-1:0][NOTE_WIDTH-1:0] note_q, note_d;
   logic [NV-1:0]                 load_q, load_d;
   logic [NV-1:0][SW-1:0]         latch_q, latch_d;
   logic [NV-1:0]                 flag_q, flag_d;
   logic [SW-1:0]                 mix_q, mix_d;
   logic                          srdy_q, srdy_d;
   logic [7:0]                    drop_q, drop_d;

   logic                   idle_found;
   logic [IW-1:0]          idle_idx;
   logic [IW-1:0]          min_idx;
   logic [DUR_WIDTH-1:0]   min_val;
   logic [IW-1:0]          sel;
   logic                   take;
   logic                   tick;
   logic signed [AW-1:0]   acc;
   logic [SW-1:0]          sat;

   // Victim search uses start-of-cycle counts; lowest index wins ties.
   always_comb begin
      idle_found = 1'b0;
      idle_idx   = '0;
      for (int i = NV - 1; i >= 0; i--) begin
         if (cnt_q[i] == '0) begin
            idle_found = 1'b1;
            idle_idx   = IW'(i);
         end
      end
      min_idx = '0;
      min_val = cnt_q[0];
      for (int i = 1; i < NV; i++) begin
         if (cnt_q[i] < min_val) begin
            min_idx = IW'(i);
            min_val = cnt_q[i];
         end
      end
   end

   always_comb begin
      acc = '0;
      for (int i = 0; i < NV; i++) begin
         if (cnt_q[i] != '0)
            acc = acc + AW'(signed'(latch_q[i]));
      end
      if (acc > MAXV)
         sat = MAXV[SW-1:0];
      else if (acc < MINV)
         sat = MINV[SW-1:0];
      else
         sat = acc[SW-1:0];
   end

   always_comb begin
      cnt_d   = cnt_q;
      timer_d = timer_q;
      note_d  = note_q;
      load_d  = '0;
      latch_d = latch_q;
      flag_d  = flag_q;
      mix_d   = mix_q;
      srdy_d  = 1'b0;
      drop_d  = drop_q;
      sel     = idle_found ? idle_idx : min_idx;
      take    = idle_found || STEAL_EN;
      tick    = beat && (timer_q != '0);
      if (play_enable) begin
         if (tick) begin
            timer_d = timer_q - 1'b1;
            for (int i = 0; i < NV; i++) begin
               if (cnt_q[i] != '0)
                  cnt_d[i] = cnt_q[i] - 1'b1;
            end
         end
         if (load_new_note) begin
            if (advance) begin
               timer_d = duration;
            end else if (duration != '0) begin
               if (take) begin
                  cnt_d[sel]  = duration;
                  note_d[sel] = note_to_load;
                  load_d[sel] = 1'b1;
               end else if (drop_q != 8'hFF) begin
                  drop_d = drop_q + 8'd1;
               end
            end
         end
         if (&flag_q) begin
            mix_d  = sat;
            srdy_d = 1'b1;
            flag_d = '0;
         end
         // A ready in the clearing cycle re-arms its flag for the next round.
         for (int i = 0; i < NV; i++) begin
            if (voice_ready[i]) begin
               latch_d[i] = voice_sample[i*SW +: SW];
               flag_d[i]  = 1'b1;
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         cnt_q   <= '0;
         timer_q <= '0;
         note_q  <= '0;
         load_q  <= '0;
         latch_q <= '0;
         flag_q  <= '0;
         mix_q   <= '0;
         srdy_q  <= 1'b0;
         drop_q  <= '0;
      end else begin
         cnt_q   <= cnt_d;
         timer_q <= timer_d;
         note_q  <= note_d;
         load_q  <= load_d;
         latch_q <= latch_d;
         flag_q  <= flag_d;
         mix_q   <= mix_d;
         srdy_q  <= srdy_d;
         drop_q  <= drop_d;
      end
   end

   always_comb begin
      for (int i = 0; i < NV; i++)
         voice_done[i] = (cnt_q[i] == '0);
   end

   assign voice_note   = note_q;
   assign voice_load   = load_q;
   assign advance_done = (timer_q == '0);
   assign all_done     = (&voice_done) && advance_done;
   assign mix_sample   = mix_q;
   assign sample_ready = srdy_q;
   assign drop_count   = drop_q;

endmodule

// File: tb/tb_poly_chord_player.sv
// Directed bench for poly_chord_player: allocation, timing, drop/steal,
// mixing, sample handshake, reset and pause.
module tb_poly_chord_player;

   logic        clk = 1'b0;
   logic        reset;
   logic        play_enable;
   logic [5:0]  note_to_load;
   logic [5:0]  duration;
   logic        load_new_note;
   logic        advance;
   logic        beat;
   logic [63:0] voice_sample;
   logic [3:0]  voice_ready;

   logic [23:0] vn0, vn1;
   logic [3:0]  vl0, vl1, vd0, vd1;
   logic        ad0, ad1, alld0, alld1;
   logic [15:0] mix0, mix1;
   logic        sr0, sr1;
   logic [7:0]  dc0, dc1;

   int tests = 0;
   int fails = 0;

   always #5 clk = ~clk;

   poly_chord_player u0 (
      .clk(clk), .reset(reset), .play_enable(play_enable),
      .note_to_load(note_to_load), .duration(duration),
      .load_new_note(load_new_note), .advance(advance), .beat(beat),
      .voice_sample(voice_sample), .voice_ready(voice_ready),
      .voice_note(vn0), .voice_load(vl0), .voice_done(vd0),
      .advance_done(ad0), .all_done(alld0), .mix_sample(mix0),
      .sample_ready(sr0), .drop_count(dc0));

   poly_chord_player #(.STEAL_EN(1'b1)) u1 (
      .clk(clk), .reset(reset), .play_enable(play_enable),
      .note_to_load(note_to_load), .duration(duration),
      .load_new_note(load_new_note), .advance(advance), .beat(beat),
      .voice_sample(voice_sample), .voice_ready(voice_ready),
      .voice_note(vn1), .voice_load(vl1), .voice_done(vd1),
      .advance_done(ad1), .all_done(alld1), .mix_sample(mix1),
      .sample_ready(sr1), .drop_count(dc1));

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [63:0] obs,
                        input logic [63:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic load(input logic adv, input logic [5:0] n,
                       input logic [5:0] d);
      advance       = adv;
      note_to_load  = n;
      duration      = d;
      load_new_note = 1'b1;
      step();
      load_new_note = 1'b0;
      advance       = 1'b0;
   endtask

   task automatic beats(input int n);
      for (int k = 0; k < n; k++) begin
         beat = 1'b1;
         step();
         beat = 1'b0;
      end
   endtask

   task automatic do_reset();
      reset = 1'b0;
      step();
      reset = 1'b1;
   endtask

   initial begin
      reset = 1'b0; play_enable = 1'b1; note_to_load = '0; duration = '0;
      load_new_note = 1'b0; advance = 1'b0; beat = 1'b0;
      voice_sample = '0; voice_ready = '0;
      step(); step();
      reset = 1'b1;
      check("rst_done", vd0, 4'hF);
      check("rst_all_done", alld0, 1'b1);
      check("rst_note", vn0, 24'h0);
      check("rst_mix", {sr0, mix0}, 17'h0);
      check("rst_drop", dc0, 8'h0);

      // Chord allocation and timing
      load(1'b1, 6'd0, 6'd10);
      load(1'b0, 6'd5, 6'd4);
      check("vload0", vl0, 4'b0001);
      check("vnote0", vn0[5:0], 6'd5);
      load(1'b0, 6'd9, 6'd4);
      check("vload1", vl0, 4'b0010);
      check("vnote1", vn0[11:6], 6'd9);
      load(1'b0, 6'd12, 6'd4);
      check("vload2", vl0, 4'b0100);
      check("vnote2", vn0[17:12], 6'd12);
      step();
      check("vload_clear", vl0, 4'b0000);
      beats(3);
      check("chord_busy", vd0, 4'b1000);
      beats(1);
      check("chord_done", vd0, 4'hF);
      check("chord_all_done", alld0, 1'b0);
      beats(5);
      check("timer_1", ad0, 1'b0);
      beats(1);
      check("timer_0", {ad0, alld0}, 2'b11);

      // Sustain while timer is zero
      do_reset();
      load(1'b0, 6'd20, 6'd3);
      beats(5);
      check("sustain", vd0[0], 1'b0);
      load(1'b1, 6'd0, 6'd2);
      beats(2);
      check("sustain_cnt1", {ad0, vd0[0]}, 2'b10);
      load(1'b1, 6'd0, 6'd1);
      beats(1);
      check("sustain_cnt0", vd0[0], 1'b1);

      // Load wins over a simultaneous beat on the loaded voice
      do_reset();
      load(1'b1, 6'd0, 6'd5);
      load(1'b0, 6'd1, 6'd2);
      beat = 1'b1;
      load(1'b0, 6'd2, 6'd1);
      beat = 1'b0;
      check("load_wins", vd0, 4'b1100);
      beats(1);
      check("load_wins_end", vd0, 4'hF);

      // Drop with all voices busy (u0), steal (u1)
      do_reset();
      load(1'b0, 6'd1, 6'd10);
      load(1'b0, 6'd2, 6'd10);
      load(1'b0, 6'd3, 6'd10);
      load(1'b0, 6'd4, 6'd10);
      load(1'b0, 6'd60, 6'd0);
      check("zero_dur_ignored", dc0, 8'd0);
      load(1'b0, 6'd50, 6'd5);
      check("drop_no_vload", vl0, 4'b0000);
      check("drop_1", dc0, 8'd1);
      for (int k = 0; k < 299; k++)
         load(1'b0, 6'd50, 6'd5);
      check("drop_sat", dc0, 8'd255);
      check("drop_notes", vn0, {6'd4, 6'd3, 6'd2, 6'd1});

      do_reset();
      load(1'b0, 6'd1, 6'd5);
      load(1'b0, 6'd2, 6'd2);
      load(1'b0, 6'd3, 6'd2);
      load(1'b0, 6'd4, 6'd7);
      load(1'b0, 6'd40, 6'd9);
      check("steal_vload", vl1, 4'b0010);
      check("steal_notes", vn1, {6'd4, 6'd3, 6'd40, 6'd1});

      // Saturating mix; voices 0,1 busy, voice 2 idle
      do_reset();
      load(1'b0, 6'd1, 6'd8);
      load(1'b0, 6'd2, 6'd8);
      voice_sample = {16'h0000, 16'h7000, 16'h7000, 16'h7000};
      voice_ready = 4'hF; step(); voice_ready = 4'h0; step();
      check("mix_pos_sat", {sr0, mix0}, {1'b1, 16'h7FFF});
      step();
      check("srdy_pulse", sr0, 1'b0);
      voice_sample = {16'h0000, 16'h9000, 16'h9000, 16'h9000};
      voice_ready = 4'hF; step(); voice_ready = 4'h0; step();
      check("mix_neg_sat", mix0, 16'h8000);
      voice_sample = {16'h0000, 16'h4000, 16'h2000, 16'h1000};
      voice_ready = 4'hF; step(); voice_ready = 4'h0; step();
      check("mix_idle_excl", mix0, 16'h3000);

      // Staggered readies and ready in the clearing cycle
      voice_ready = 4'b0001; step();
      voice_ready = 4'b0010; step();
      voice_ready = 4'b0100; step();
      check("stag_wait", sr0, 1'b0);
      voice_ready = 4'b1000; step();
      check("stag_wait3", sr0, 1'b0);
      voice_ready = 4'b0001; step();
      check("stag_ready", sr0, 1'b1);
      voice_ready = 4'b0010; step();
      check("stag_once", sr0, 1'b0);
      voice_ready = 4'b0100; step();
      voice_ready = 4'b1000; step();
      check("stag_round2_wait", sr0, 1'b0);
      voice_ready = 4'b0000; step();
      check("stag_round2", sr0, 1'b1);

      // Reset overrides a concurrent beat and load
      load(1'b1, 6'd0, 6'd9);
      reset = 1'b0; beat = 1'b1; load_new_note = 1'b1;
      note_to_load = 6'd33; duration = 6'd5;
      step();
      reset = 1'b1; beat = 1'b0; load_new_note = 1'b0;
      check("rst_mid_done", {alld0, ad0, vd0}, 6'h3F);
      check("rst_mid_out", {vl0, vn0, sr0, mix0, dc0}, 53'h0);
      load(1'b0, 6'd7, 6'd3);
      check("rst_first_v0", vl0, 4'b0001);

      // Pause freezes counts, loads and sample_ready
      load(1'b1, 6'd0, 6'd5);
      play_enable = 1'b0;
      for (int k = 0; k < 3; k++) begin
         voice_ready = 4'hF; beat = 1'b1;
         step();
         check("pause_no_srdy", sr0, 1'b0);
      end
      voice_ready = 4'h0; beat = 1'b0;
      load(1'b0, 6'd8, 6'd4);
      check("pause_no_load", {vl0, vd0}, {4'b0000, 4'b1110});
      step();
      check("pause_no_srdy2", sr0, 1'b0);
      play_enable = 1'b1;
      beats(2);
      check("pause_frozen", vd0[0], 1'b0);
      beats(1);
      check("pause_resume", vd0[0], 1'b1);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/poly_chord_player.md
POLY_CHORD_PLAYER -- requirements
Module: poly_chord_player

Interface
REQ-001 Parameter NUM_VOICES, default 4, number of voices, legal 1..8.
REQ-002 Parameter NOTE_WIDTH, default 6, note code width.
REQ-003 Parameter DUR_WIDTH, default 6, duration counter width, in beats.
REQ-004 Parameter SAMPLE_WIDTH, default 16, signed sample width per voice and for the mix.
REQ-005 Parameter STEAL_EN, default 0: 0 drops a note when all voices are busy, 1 steals a voice.
REQ-006 The block SHALL have one clock; reset is synchronous and active-low; ports are named clk and reset.
REQ-007 clk  in  1  system clock.
REQ-008 reset  in  1  synchronous, active-low.
REQ-009 play_enable  in  1  run/pause.
REQ-010 note_to_load  in  NOTE_WIDTH  note to allocate.
REQ-011 duration  in  DUR_WIDTH  beats to hold the note.
REQ-012 load_new_note  in  1  one-cycle load strobe.
REQ-013 advance  in  1  qualifies a load as an advance-timer load, not a note.
REQ-014 beat  in  1  one-cycle 1/48 s tick.
REQ-015 voice_sample  in  NUM_VOICES*SAMPLE_WIDTH  per-voice samples; voice i is at bits [i*SAMPLE_WIDTH +: SAMPLE_WIDTH].
REQ-016 voice_ready  in  NUM_VOICES  per-voice sample-valid pulses.
REQ-017 voice_note  out  NUM_VOICES*NOTE_WIDTH  registered note per voice.
REQ-018 voice_load  out  NUM_VOICES  one-cycle per-voice load pulse.
REQ-019 voice_done  out  NUM_VOICES  voice idle (count==0).
REQ-020 advance_done  out  1  advance timer == 0.
REQ-021 all_done  out  1  all voices idle AND advance_done.
REQ-022 mix_sample  out  SAMPLE_WIDTH  registered saturated mix.
REQ-023 sample_ready  out  1  one-cycle pulse when mix_sample updates.
REQ-024 drop_count  out  8  count of dropped notes, saturates at 255.

Function
REQ-025 Each voice SHALL hold a DUR_WIDTH count; count==0 means idle; the advance timer is also DUR_WIDTH wide.
REQ-026 Loads, beat decrements and sample_ready SHALL occur only while play_enable=1; when play_enable=0, all state freezes and sample_ready=0.
REQ-027 A load with advance=1 SHALL set timer=duration unconditionally, with no voice change.
REQ-028 A load with advance=0 and duration!=0 SHALL allocate the lowest-index idle voice, using counts from the start of the cycle: count<=duration, and voice_note[i]<=note_to_load.
REQ-029 A load with advance=0 and duration==0 SHALL be ignored: no allocation and no drop.
REQ-030 With all voices busy and STEAL_EN=0, the note SHALL be dropped and drop_count SHALL increment, saturating.
REQ-031 With all voices busy and STEAL_EN=1, the voice with the minimum count SHALL be reloaded; ties go to the lowest index.
REQ-032 voice_load[i] SHALL pulse high exactly one cycle, in the cycle after the accepted load, coincident with the updated voice_note[i].
REQ-033 On beat with timer!=0, each voice with count!=0 SHALL decrement by 1, and the timer SHALL decrement by 1.
REQ-034 With timer==0, voice counts SHALL hold (the chord sustains until the next advance load).
REQ-035 A load and a beat hitting the same voice or the timer in one cycle: the load SHALL win and no decrement applies that cycle.
REQ-036 Counts SHALL never wrap below 0.
REQ-037 On voice_ready[i], the block SHALL latch voice i's sample and set sticky flag i; a ready arriving while flag i is already set SHALL overwrite the latch.
REQ-038 When all NUM_VOICES flags are set, on the next clk:
  - mix_sample <= the sum of latched samples of voices with count!=0, sign-extended, with idle voices contributing 0;
  - the sum saturates to [-2^(SAMPLE_WIDTH-1), 2^(SAMPLE_WIDTH-1)-1];
  - sample_ready pulses for 1 cycle;
  - all flags clear.
REQ-039 A voice_ready in the clearing cycle SHALL set its flag for the next round (it is not lost).
REQ-040 voice_done, advance_done and all_done SHALL be combinational from the registered counts.

Reset
REQ-041 reset=0 at a clk edge SHALL clear the following, overriding every other event that cycle:
  - all counts, the timer, voice_note, voice_load, the latches, the flags, mix_sample, sample_ready and drop_count go to 0;
  - voice_done, advance_done and all_done therefore read all 1s.
REQ-042 Reset mid-note SHALL abandon all notes; the first load after reset SHALL allocate voice 0.

Verification
REQ-043 Reset, then advance load dur=10, then three note loads (notes 5, 9, 12; dur=4) -> voices 0, 1, 2 get them; each voice_load is a 1-cycle pulse; after 4 beats all three are voice_done=1 and the timer reads 6.
REQ-044 Timer=0 with voice 0 count=3, then 5 beats -> count stays 3; after an advance load dur=2 and 2 beats, count reads 1.
REQ-045 STEAL_EN=0, all 4 voices busy, 300 extra loads -> drop_count=255 and no voice changes; with STEAL_EN=1 and counts {5,2,2,7}, one load -> voice 1 is reloaded.
REQ-046 SAMPLE_WIDTH=16, two busy voices at 0x7000 each -> mix_sample=0x7FFF; at 0x9000 each -> 0x8000; an idle voice's sample is excluded.
REQ-047 Readies staggered over voices 0..3 across 4 cycles -> exactly one sample_ready, 1 cycle after voice 3; a voice 0 ready in the clear cycle counts toward the next round.
REQ-048 reset=0 asserted during a beat and a load -> all outputs are at reset values the next cycle; play_enable=0 with beats -> counts frozen and no sample_ready.
